// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, control-word
// bit positions, the idle control word and the sequencer FSM encodings.
package cpu_pkg;

  // Opcodes as they appear in the upper nibble of the instruction register
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit positions: {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
  localparam int CTRL_CP   = 14;
  localparam int CTRL_EP   = 13;
  localparam int CTRL_LP   = 12;
  localparam int CTRL_NLMA = 11;
  localparam int CTRL_NLMD = 10;
  localparam int CTRL_NCE  = 9;
  localparam int CTRL_NLR  = 8;
  localparam int CTRL_NLI  = 7;
  localparam int CTRL_NEI  = 6;
  localparam int CTRL_NLA  = 5;
  localparam int CTRL_EA   = 4;
  localparam int CTRL_SUB  = 3;
  localparam int CTRL_EU   = 2;
  localparam int CTRL_NLB  = 1;
  localparam int CTRL_NLO  = 0;

  // Every active-low strobe deasserted (high), every active-high strobe low
  localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

  // Sequencer FSM encodings
  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: maps {opcode, T-state, CF, ZF} to the raw
// control word and a flag marking the final microstep of the instruction.
module microcode_rom
  import cpu_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int CTRL_W       = 15,
  parameter int T_STATES     = 6,
  parameter int FETCH_STATES = 3,
  localparam int TW          = $clog2(T_STATES)
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [TW-1:0]       tstate,
  input  logic                cf,
  input  logic                zf,
  output logic [CTRL_W-1:0]   ctrl_raw,
  output logic                last
);

  logic [TW-1:0] step;

  // Execute-phase step index, counted from the first step after fetch
  assign step = tstate - TW'(FETCH_STATES);

  // Table lookup; undefined execute steps fall back to idle and terminate
  always_comb begin
    ctrl_raw = CTRL_W'(CTRL_IDLE);
    last     = 1'b0;
    if (tstate < TW'(FETCH_STATES)) begin
      if (tstate == TW'(0)) begin
        ctrl_raw[CTRL_EP]   = 1'b1;
        ctrl_raw[CTRL_NLMA] = 1'b0;
      end else if (tstate == TW'(1)) begin
        ctrl_raw[CTRL_CP]   = 1'b1;
      end else begin
        ctrl_raw[CTRL_NCE]  = 1'b0;
        ctrl_raw[CTRL_NLI]  = 1'b0;
      end
    end else begin
      last = 1'b1;
      case (opcode)
        OPCODE_W'(OP_LDA): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_NLMA] = 1'b0;
            last                = 1'b0;
          end else if (step == TW'(1)) begin
            ctrl_raw[CTRL_NCE]  = 1'b0;
            ctrl_raw[CTRL_NLA]  = 1'b0;
          end
        end
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_NLMA] = 1'b0;
            last                = 1'b0;
          end else if (step == TW'(1)) begin
            ctrl_raw[CTRL_NCE]  = 1'b0;
            ctrl_raw[CTRL_NLB]  = 1'b0;
            last                = 1'b0;
          end else if (step == TW'(2)) begin
            ctrl_raw[CTRL_EU]   = 1'b1;
            ctrl_raw[CTRL_NLA]  = 1'b0;
            ctrl_raw[CTRL_SUB]  = (opcode == OPCODE_W'(OP_SUB));
          end
        end
        OPCODE_W'(OP_STA): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_NLMA] = 1'b0;
            last                = 1'b0;
          end else if (step == TW'(1)) begin
            ctrl_raw[CTRL_EA]   = 1'b1;
            ctrl_raw[CTRL_NLMD] = 1'b0;
            last                = 1'b0;
          end else if (step == TW'(2)) begin
            ctrl_raw[CTRL_NLR]  = 1'b0;
          end
        end
        OPCODE_W'(OP_LDI): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_NLA]  = 1'b0;
          end
        end
        OPCODE_W'(OP_JMP): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_LP]   = 1'b1;
          end
        end
        OPCODE_W'(OP_JC), OPCODE_W'(OP_JZ): begin
          // Jump taken only when the selected flag is set; otherwise idle
          if (step == TW'(0) &&
              ((opcode == OPCODE_W'(OP_JC)) ? cf : zf)) begin
            ctrl_raw[CTRL_NEI]  = 1'b0;
            ctrl_raw[CTRL_LP]   = 1'b1;
          end
        end
        OPCODE_W'(OP_OUT): begin
          if (step == TW'(0)) begin
            ctrl_raw[CTRL_EA]   = 1'b1;
            ctrl_raw[CTRL_NLO]  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit CPU: owns the RST/RUN/HALT FSM and the
// T-state counter, masks the ROM output while stalled or idle, and reports
// instruction completion and halt.
module microcode_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int CTRL_W       = 15,
  parameter int T_STATES     = 6,
  parameter int FETCH_STATES = 3,
  localparam int TW          = $clog2(T_STATES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cf,
  input  logic                zf,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [TW-1:0]       tstate,
  output logic                instr_done,
  output logic                halted
);

  if (T_STATES < FETCH_STATES + 3) begin : g_tstates_too_small
    $error("microcode_sequencer: T_STATES must be >= FETCH_STATES+3");
  end

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tstate_q, tstate_d;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              last;
  logic              exec_hlt;

  microcode_rom #(
    .OPCODE_W     (OPCODE_W),
    .CTRL_W       (CTRL_W),
    .T_STATES     (T_STATES),
    .FETCH_STATES (FETCH_STATES)
  ) u_rom (
    .opcode   (opcode),
    .tstate   (tstate_q),
    .cf       (cf),
    .zf       (zf),
    .ctrl_raw (ctrl_raw),
    .last     (last)
  );

  // The IR only holds a valid opcode once fetch is over
  assign exec_hlt = (opcode == OPCODE_W'(OP_HLT)) && (tstate_q >= TW'(FETCH_STATES));

  // FSM/counter next state plus output masking for stall, reset and halt
  always_comb begin
    state_d    = state_q;
    tstate_d   = tstate_q;
    ctrl       = CTRL_W'(CTRL_IDLE);
    instr_done = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d  = ST_RUN;
        tstate_d = '0;
      end
      ST_RUN: begin
        if (ena) begin
          ctrl = ctrl_raw;
          // Hard wrap at the last T-state covers a ROM entry with no last bit
          if (last || tstate_q == TW'(T_STATES - 1)) begin
            tstate_d   = '0;
            instr_done = 1'b1;
            if (exec_hlt) state_d = ST_HALT;
          end else begin
            tstate_d = tstate_q + TW'(1);
          end
        end
      end
      ST_HALT: tstate_d = '0;
      default: begin
        state_d  = ST_RST;
        tstate_d = '0;
      end
    endcase
  end

  // State and T-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      tstate_q <= '0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
    end
  end

  assign tstate = tstate_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: walks reset, fetch and every
// instruction class, stall and halt against hand-computed control words.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  opcode;
  logic        cf;
  logic        zf;
  logic [14:0] ctrl;
  logic [2:0]  tstate;
  logic        instr_done;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .opcode     (opcode),
    .cf         (cf),
    .zf         (zf),
    .ctrl       (ctrl),
    .tstate     (tstate),
    .instr_done (instr_done),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Check one microstep's outputs shortly after the inputs settle, then move to the next negedge
  task automatic step(input string tag, input int ts, input logic [14:0] c, input logic d);
    #1;
    check({tag, ".tstate"}, 32'(tstate), ts);
    check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    check({tag, ".done"}, 32'(instr_done), 32'(d));
    check({tag, ".halted"}, 32'(halted), 32'd0);
    @(negedge clk);
  endtask

  // Shared fetch; opcode holds junk (HLT) at T0 since the IR is not loaded yet
  task automatic fetch(input string tag, input logic [3:0] op);
    opcode = 4'hF;
    step({tag, ".T0"}, 0, 15'h27E3, 1'b0);
    opcode = op;
    step({tag, ".T1"}, 1, 15'h4FE3, 1'b0);
    step({tag, ".T2"}, 2, 15'h0D63, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.ctrl", 32'(ctrl), 32'h0FE3);
    check("rst.tstate", 32'(tstate), 32'd0);
    check("rst.done", 32'(instr_done), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstcyc.ctrl", 32'(ctrl), 32'h0FE3);
    check("rstcyc.tstate", 32'(tstate), 32'd0);
    @(negedge clk);

    // LDI
    fetch("ldi", 4'h5);
    step("ldi.T3", 3, 15'h0F83, 1'b1);
    // ADD
    fetch("add", 4'h2);
    step("add.T3", 3, 15'h07A3, 1'b0);
    step("add.T4", 4, 15'h0DE1, 1'b0);
    step("add.T5", 5, 15'h0FC7, 1'b1);
    // SUB
    fetch("sub", 4'h3);
    step("sub.T3", 3, 15'h07A3, 1'b0);
    step("sub.T4", 4, 15'h0DE1, 1'b0);
    step("sub.T5", 5, 15'h0FCF, 1'b1);
    // STA
    fetch("sta", 4'h4);
    step("sta.T3", 3, 15'h07A3, 1'b0);
    step("sta.T4", 4, 15'h0BF3, 1'b0);
    step("sta.T5", 5, 15'h0EE3, 1'b1);
    // JC not taken / taken
    cf = 1'b0; zf = 1'b1;
    fetch("jc0", 4'h7);
    step("jc0.T3", 3, 15'h0FE3, 1'b1);
    cf = 1'b1; zf = 1'b0;
    fetch("jc1", 4'h7);
    step("jc1.T3", 3, 15'h1FA3, 1'b1);
    // JZ not taken / taken
    fetch("jz0", 4'h8);
    step("jz0.T3", 3, 15'h0FE3, 1'b1);
    cf = 1'b0; zf = 1'b1;
    fetch("jz1", 4'h8);
    step("jz1.T3", 3, 15'h1FA3, 1'b1);
    zf = 1'b0;
    // JMP, OUT, unlisted opcode
    fetch("jmp", 4'h6);
    step("jmp.T3", 3, 15'h1FA3, 1'b1);
    fetch("out", 4'hE);
    step("out.T3", 3, 15'h0FF2, 1'b1);
    fetch("nopA", 4'hA);
    step("nopA.T3", 3, 15'h0FE3, 1'b1);
    // LDA with a 2-cycle stall at T4
    fetch("lda", 4'h1);
    step("lda.T3", 3, 15'h07A3, 1'b0);
    ena = 1'b0;
    step("lda.stall0", 4, 15'h0FE3, 1'b0);
    step("lda.stall1", 4, 15'h0FE3, 1'b0);
    ena = 1'b1;
    step("lda.T4", 4, 15'h0DC3, 1'b1);
    // HLT
    fetch("hlt", 4'hF);
    step("hlt.T3", 3, 15'h0FE3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt.halted", 32'(halted), 32'd1);
      check("halt.ctrl", 32'(ctrl), 32'h0FE3);
      check("halt.tstate", 32'(tstate), 32'd0);
      check("halt.done", 32'(instr_done), 32'd0);
      @(negedge clk);
    end
    // Asynchronous reset out of HALT
    rst_n = 1'b0;
    #1;
    check("halt_rst.halted", 32'(halted), 32'd0);
    check("halt_rst.ctrl", 32'(ctrl), 32'h0FE3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("halt_rst.rstcyc", 32'(ctrl), 32'h0FE3);
    @(negedge clk);
    fetch("post", 4'h5);
    step("post.T3", 3, 15'h0F83, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
